j_collector_mx_cell: RTL

// - Receive end of the 8-lane bit-serial datapath. Takes 8 independent serial streams
//   (one per shifter lane, per-lane valid), deserialises each into 8-bit words, MSB first.
// - Writes completed words back through one shared SRAM write port.
// - Lane i stores its words consecutively from its own start address.

---
 rtl/j_collector_mx_cell_pkg.sv | 30 +++
 rtl/j_collector_mx_cell_deser.sv | 84 ++++++++
 rtl/j_collector_mx_cell.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/j_collector_mx_cell_pkg.sv
// Shared constants, state encoding and width helper for the bit-serial collector.
package j_collector_mx_cell_pkg;

  // Ceiling log2. The result is at least 1 so that a depth of 1 still gets a legal address width.
  function automatic int clog2(input int unsigned value);
    int unsigned v;
    int          r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

  localparam int SRAM_DEPTH_DEF  = 256 * 256 * 4;
  localparam int SRAM_ADDR_W_DEF = clog2(SRAM_DEPTH_DEF);
  localparam int LANES           = 8;
  localparam int LANE_W          = 3;
  localparam int WORD_W          = 8;
  localparam int BIT_CNT_W       = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/j_collector_mx_cell_deser.sv
// One receive lane: MSB-first shift register, bit counter, 1-deep pending word,
// received/written word counters and a done flag for the top-level FSM.
module j_collector_mx_cell_deser
  import j_collector_mx_cell_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_clear,
  input  logic              i_busy,
  input  logic              i_ser_data,
  input  logic              i_ser_en,
  input  logic [ADDR_W-1:0] i_word_count,
  input  logic              i_grant,
  output logic              o_pending,
  output logic [WORD_W-1:0] o_word,
  output logic [ADDR_W-1:0] o_word_idx,
  output logic              o_done,
  output logic              o_overflow
);

  logic [WORD_W-1:0]    r_shift;
  logic [WORD_W-1:0]    r_pend_word;
  logic                 r_pending;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [ADDR_W-1:0]    r_rx_cnt;
  logic [ADDR_W-1:0]    r_wr_cnt;

  logic                 w_accept;
  logic                 w_complete;
  logic                 w_collide;
  logic [WORD_W-1:0]    w_new_word;

  // Bits are taken only while a run is active and this lane still owes words.
  assign w_accept   = i_busy && i_ser_en && (r_rx_cnt < i_word_count);
  assign w_complete = w_accept && (r_bit_cnt == BIT_CNT_W'(WORD_W - 1));
  assign w_new_word = {r_shift[WORD_W-2:0], i_ser_data};
  // A completion that finds the pending slot occupied and not draining this cycle loses the word.
  assign w_collide  = w_complete && r_pending && !i_grant;

  // Lane capture, pending slot and word bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_shift     <= '0;
      r_pend_word <= '0;
      r_pending   <= 1'b0;
      r_bit_cnt   <= '0;
      r_rx_cnt    <= '0;
      r_wr_cnt    <= '0;
    end else if (i_clear) begin
      r_shift     <= '0;
      r_pending   <= 1'b0;
      r_bit_cnt   <= '0;
      r_rx_cnt    <= '0;
      r_wr_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_shift   <= w_new_word;
        r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
      end
      if (w_complete) begin
        r_rx_cnt <= r_rx_cnt + ADDR_W'(1);
      end
      if (i_grant) begin
        r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
      end
      // A fresh word wins over a same-cycle drain, so the slot stays full with the new data.
      if (w_complete && !w_collide) begin
        r_pending   <= 1'b1;
        r_pend_word <= w_new_word;
      end else if (i_grant) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign o_pending  = r_pending;
  assign o_word     = r_pend_word;
  assign o_word_idx = r_wr_cnt;
  assign o_done     = (r_wr_cnt == i_word_count);
  assign o_overflow = w_collide;

endmodule

// File: rtl/j_collector_mx_cell.sv
// Receive end of the 8-lane bit-serial datapath: run FSM, round-robin arbiter
// over the lane pending slots and the registered shared SRAM write port.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | no run; lane inputs ignored, waiting for collect_start
//   ST_BUSY | run active; lanes capture, arbiter drains words to the SRAM
module j_collector_mx_cell
  import j_collector_mx_cell_pkg::*;
#(
  parameter int SRAM_DEPTH  = SRAM_DEPTH_DEF,
  parameter int SRAM_ADDR_W = clog2(SRAM_DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         collect_start,
  output logic                         collect_idle,
  input  logic [SRAM_ADDR_W*LANES-1:0] start_addr,
  input  logic [SRAM_ADDR_W-1:0]       word_count,
  input  logic [LANES-1:0]             serial_input,
  input  logic [LANES-1:0]             serial_en,
  output logic                         sram_en,
  output logic [SRAM_ADDR_W-1:0]       sram_addr,
  output logic [WORD_W-1:0]            sram_wdata,
  output logic                         overflow
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_clear;
  logic                   w_busy;

  logic [SRAM_ADDR_W-1:0] r_start_addr [LANES];
  logic [SRAM_ADDR_W-1:0] r_word_count;

  logic [LANES-1:0]       w_pending;
  logic [LANES-1:0]       w_done;
  logic [LANES-1:0]       w_lane_ovf;
  logic [WORD_W-1:0]      w_word     [LANES];
  logic [SRAM_ADDR_W-1:0] w_word_idx [LANES];

  logic [LANE_W-1:0]      r_rr_ptr;
  logic [LANE_W-1:0]      w_scan_idx;
  logic [LANE_W-1:0]      w_grant_lane;
  logic                   w_grant_any;
  logic [LANES-1:0]       w_grant_vec;

  logic                   r_sram_en;
  logic [SRAM_ADDR_W-1:0] r_sram_addr;
  logic [WORD_W-1:0]      r_sram_wdata;
  logic                   r_overflow;

  assign w_busy = (r_state == ST_BUSY);

  // Run state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; a run ends once every lane has written its quota and nothing is left pending.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (collect_start) begin
          w_state_nxt = ST_BUSY;
          w_clear     = 1'b1;
        end
      end
      ST_BUSY: begin
        if ((&w_done) && !(|w_pending)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Run parameters are frozen at the start of a run so the host may change them freely afterwards.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < LANES; i++) begin
        r_start_addr[i] <= '0;
      end
      r_word_count <= '0;
    end else if (w_clear) begin
      for (int i = 0; i < LANES; i++) begin
        r_start_addr[i] <= start_addr[i*SRAM_ADDR_W +: SRAM_ADDR_W];
      end
      r_word_count <= word_count;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    j_collector_mx_cell_deser #(
      .ADDR_W (SRAM_ADDR_W)
    ) u_deser (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_clear      (w_clear),
      .i_busy       (w_busy),
      .i_ser_data   (serial_input[g]),
      .i_ser_en     (serial_en[g]),
      .i_word_count (r_word_count),
      .i_grant      (w_grant_vec[g]),
      .o_pending    (w_pending[g]),
      .o_word       (w_word[g]),
      .o_word_idx   (w_word_idx[g]),
      .o_done       (w_done[g]),
      .o_overflow   (w_lane_ovf[g])
    );
  end

  // Round-robin pick: first pending lane at or after the pointer, wrapping around.
  always_comb begin
    w_grant_vec  = '0;
    w_grant_any  = 1'b0;
    w_grant_lane = '0;
    w_scan_idx   = '0;
    for (int k = 0; k < LANES; k++) begin
      w_scan_idx = r_rr_ptr + LANE_W'(k);
      if (!w_grant_any && w_busy && w_pending[w_scan_idx]) begin
        w_grant_any  = 1'b1;
        w_grant_lane = w_scan_idx;
      end
    end
    if (w_grant_any) begin
      w_grant_vec[w_grant_lane] = 1'b1;
    end
  end

  // Registered write port; address and data hold between writes, pointer moves past the winner.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sram_en    <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_rr_ptr     <= '0;
    end else begin
      r_sram_en <= w_grant_any;
      if (w_grant_any) begin
        r_sram_addr  <= r_start_addr[w_grant_lane] + w_word_idx[w_grant_lane];
        r_sram_wdata <= w_word[w_grant_lane];
        r_rr_ptr     <= w_grant_lane + LANE_W'(1);
      end
    end
  end

  // Sticky loss indicator, cleared only when a new run starts.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_clear) begin
      r_overflow <= 1'b0;
    end else if (|w_lane_ovf) begin
      r_overflow <= 1'b1;
    end
  end

  assign collect_idle = (r_state == ST_IDLE);
  assign sram_en      = r_sram_en;
  assign sram_addr    = r_sram_addr;
  assign sram_wdata   = r_sram_wdata;
  assign overflow     = r_overflow;

endmodule
